// File: rtl/issue_queue_age.sv
// 16-entry out-of-order issue queue with compact per-entry ages (0 = oldest),
// tag wakeup, lowest-free-slot allocation and grant-driven issue.
module issue_queue_age #(
  parameter int OPCODE_WIDTH = 7,
  parameter int AGE          = 5,
  parameter int TAG_WIDTH    = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPCODE_WIDTH-1:0]  in_op,
  input  logic [TAG_WIDTH-1:0]     in_src1_tag,
  input  logic [TAG_WIDTH-1:0]     in_src2_tag,
  input  logic                     in_src1_rdy,
  input  logic                     in_src2_rdy,
  input  logic [TAG_WIDTH-1:0]     in_dst_tag,
  input  logic                     wakeup_valid,
  input  logic [TAG_WIDTH-1:0]     wakeup_tag,
  output logic [16*OPCODE_WIDTH-1:0] entry_op,
  output logic [15:0]              entry_req,
  output logic [16*AGE-1:0]        entry_age,
  input  logic                     grant_valid,
  input  logic [3:0]               grant_addr,
  output logic                     issue_valid,
  output logic [OPCODE_WIDTH-1:0]  issue_op,
  output logic [TAG_WIDTH-1:0]     issue_src1_tag,
  output logic [TAG_WIDTH-1:0]     issue_src2_tag,
  output logic [TAG_WIDTH-1:0]     issue_dst_tag,
  output logic [4:0]               count
);
  localparam int N = 16;

  logic                    valid_reg   [N];
  logic [OPCODE_WIDTH-1:0] op_reg      [N];
  logic [TAG_WIDTH-1:0]    s1_tag_reg  [N];
  logic [TAG_WIDTH-1:0]    s2_tag_reg  [N];
  logic                    s1_rdy_reg  [N];
  logic                    s2_rdy_reg  [N];
  logic [TAG_WIDTH-1:0]    dst_tag_reg [N];
  logic [AGE-1:0]          age_reg     [N];
  logic [4:0]              count_reg;

  logic                    issue_valid_reg;
  logic [OPCODE_WIDTH-1:0] issue_op_reg;
  logic [TAG_WIDTH-1:0]    issue_src1_reg;
  logic [TAG_WIDTH-1:0]    issue_src2_reg;
  logic [TAG_WIDTH-1:0]    issue_dst_reg;

  logic [N-1:0]   req;
  logic [3:0]     alloc_idx;
  logic           alloc;
  logic           issue_fire;
  logic [AGE-1:0] grant_age;
  logic [AGE-1:0] new_age;
  logic           in_wake1;
  logic           in_wake2;
  logic [4:0]     count_next;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_entry
      assign req[gi] = valid_reg[gi] & s1_rdy_reg[gi] & s2_rdy_reg[gi];
      assign entry_op[gi*OPCODE_WIDTH +: OPCODE_WIDTH] = op_reg[gi];
      assign entry_age[gi*AGE +: AGE] = age_reg[gi];
    end
  endgenerate

  // Lowest-index free slot; uses registered valid so a slot freed this cycle is not reused.
  always_comb begin
    alloc_idx = 4'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!valid_reg[i]) alloc_idx = 4'(i);
    end
  end

  assign in_ready   = (count_reg != 5'd16);
  assign alloc      = in_valid && in_ready && !flush;
  assign issue_fire = grant_valid && req[grant_addr] && !flush;
  assign grant_age  = age_reg[grant_addr];
  assign new_age    = AGE'(count_reg) - AGE'(issue_fire);
  assign in_wake1   = wakeup_valid && (in_src1_tag == wakeup_tag);
  assign in_wake2   = wakeup_valid && (in_src2_tag == wakeup_tag);
  assign count_next = count_reg + 5'(alloc) - 5'(issue_fire);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        valid_reg[i]   <= 1'b0;
        op_reg[i]      <= '0;
        s1_tag_reg[i]  <= '0;
        s2_tag_reg[i]  <= '0;
        s1_rdy_reg[i]  <= 1'b0;
        s2_rdy_reg[i]  <= 1'b0;
        dst_tag_reg[i] <= '0;
        age_reg[i]     <= '0;
      end
      count_reg <= '0;
    end else if (flush) begin
      for (int i = 0; i < N; i++) valid_reg[i] <= 1'b0;
      count_reg <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (issue_fire && (grant_addr == 4'(i))) begin
          valid_reg[i] <= 1'b0;
        end else if (valid_reg[i] && issue_fire && (age_reg[i] > grant_age)) begin
          age_reg[i] <= age_reg[i] - 1'b1;
        end
        if (valid_reg[i] && wakeup_valid && (s1_tag_reg[i] == wakeup_tag)) s1_rdy_reg[i] <= 1'b1;
        if (valid_reg[i] && wakeup_valid && (s2_tag_reg[i] == wakeup_tag)) s2_rdy_reg[i] <= 1'b1;
        // Allocation only targets an invalid slot, so it never collides with issue/wakeup above.
        if (alloc && (alloc_idx == 4'(i))) begin
          valid_reg[i]   <= 1'b1;
          op_reg[i]      <= in_op;
          s1_tag_reg[i]  <= in_src1_tag;
          s2_tag_reg[i]  <= in_src2_tag;
          s1_rdy_reg[i]  <= in_src1_rdy | in_wake1;
          s2_rdy_reg[i]  <= in_src2_rdy | in_wake2;
          dst_tag_reg[i] <= in_dst_tag;
          age_reg[i]     <= new_age;
        end
      end
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_valid_reg <= 1'b0;
      issue_op_reg    <= '0;
      issue_src1_reg  <= '0;
      issue_src2_reg  <= '0;
      issue_dst_reg   <= '0;
    end else begin
      issue_valid_reg <= issue_fire;
      if (issue_fire) begin
        issue_op_reg   <= op_reg[grant_addr];
        issue_src1_reg <= s1_tag_reg[grant_addr];
        issue_src2_reg <= s2_tag_reg[grant_addr];
        issue_dst_reg  <= dst_tag_reg[grant_addr];
      end
    end
  end

  assign entry_req      = req;
  assign count          = count_reg;
  assign issue_valid    = issue_valid_reg;
  assign issue_op       = issue_op_reg;
  assign issue_src1_tag = issue_src1_reg;
  assign issue_src2_tag = issue_src2_reg;
  assign issue_dst_tag  = issue_dst_reg;

endmodule

// File: tb/tb_issue_queue_age.sv
// Directed bench for issue_queue_age: allocation, ages, wakeup, issue, full, flush, reset.
module tb_issue_queue_age;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_op;
  logic [5:0]  in_src1_tag, in_src2_tag, in_dst_tag;
  logic        in_src1_rdy, in_src2_rdy;
  logic        wakeup_valid;
  logic [5:0]  wakeup_tag;
  logic [111:0] entry_op;
  logic [15:0] entry_req;
  logic [79:0] entry_age;
  logic        grant_valid;
  logic [3:0]  grant_addr;
  logic        issue_valid;
  logic [6:0]  issue_op;
  logic [5:0]  issue_src1_tag, issue_src2_tag, issue_dst_tag;
  logic [4:0]  count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  issue_queue_age dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1_tag(in_src1_tag), .in_src2_tag(in_src2_tag),
    .in_src1_rdy(in_src1_rdy), .in_src2_rdy(in_src2_rdy),
    .in_dst_tag(in_dst_tag),
    .wakeup_valid(wakeup_valid), .wakeup_tag(wakeup_tag),
    .entry_op(entry_op), .entry_req(entry_req), .entry_age(entry_age),
    .grant_valid(grant_valid), .grant_addr(grant_addr),
    .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_src1_tag(issue_src1_tag), .issue_src2_tag(issue_src2_tag),
    .issue_dst_tag(issue_dst_tag), .count(count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [4:0] age_of(input int i);
    return entry_age[i*5 +: 5];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [5:0] s1, input logic r1,
                        input logic [5:0] s2, input logic r2, input logic [5:0] d);
    in_valid = v; in_op = 7'h33;
    in_src1_tag = s1; in_src1_rdy = r1;
    in_src2_tag = s2; in_src2_rdy = r2;
    in_dst_tag = d;
  endtask

  initial begin
    rst = 1'b1; flush = 0; wakeup_valid = 0; wakeup_tag = 0;
    grant_valid = 0; grant_addr = 0;
    set_in(0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_req", 32'(entry_req), 0);
    chk("rst_issue", 32'(issue_valid), 0);
    @(negedge clk); rst = 1'b0;
    #4;

    // Three ready dispatches into an empty queue
    for (int i = 0; i < 3; i++) begin
      set_in(1, 6'(20 + i), 1, 6'(30 + i), 1, 6'(10 + i));
      step();
    end
    set_in(0, 0, 0, 0, 0, 0);
    chk("disp_req", 32'(entry_req), 32'h0007);
    chk("disp_count", 32'(count), 3);
    chk("disp_age0", 32'(age_of(0)), 0);
    chk("disp_age1", 32'(age_of(1)), 1);
    chk("disp_age2", 32'(age_of(2)), 2);
    chk("disp_op1", 32'(entry_op[7 +: 7]), 32'h33);

    // Issue middle entry
    grant_valid = 1; grant_addr = 4'd1;
    step();
    grant_valid = 0;
    chk("iss_valid", 32'(issue_valid), 1);
    chk("iss_dst", 32'(issue_dst_tag), 11);
    chk("iss_src1", 32'(issue_src1_tag), 21);
    chk("iss_src2", 32'(issue_src2_tag), 31);
    chk("iss_op", 32'(issue_op), 32'h33);
    chk("iss_count", 32'(count), 2);
    chk("iss_req", 32'(entry_req), 32'h0005);
    chk("iss_age0", 32'(age_of(0)), 0);
    chk("iss_age2", 32'(age_of(2)), 1);
    step();
    chk("iss_pulse", 32'(issue_valid), 0);

    // Dispatch waiting on tag 12, then wake it
    set_in(1, 12, 0, 40, 1, 13);
    step();
    set_in(0, 0, 0, 0, 0, 0);
    chk("wait_req", 32'(entry_req), 32'h0005);
    chk("wait_age1", 32'(age_of(1)), 2);
    wakeup_valid = 1; wakeup_tag = 12;
    step();
    wakeup_valid = 0;
    chk("wake_req", 32'(entry_req), 32'h0007);
    // Same-cycle dispatch and wakeup of tag 12
    set_in(1, 12, 0, 41, 1, 14);
    wakeup_valid = 1; wakeup_tag = 12;
    step();
    set_in(0, 0, 0, 0, 0, 0); wakeup_valid = 0;
    chk("samewk_req", 32'(entry_req), 32'h000F);
    chk("samewk_age3", 32'(age_of(3)), 3);
    chk("samewk_count", 32'(count), 4);

    // Fill to 16
    for (int i = 4; i < 16; i++) begin
      set_in(1, 42, 1, 43, 1, 6'(i));
      step();
    end
    chk("full_count", 32'(count), 16);
    chk("full_ready", 32'(in_ready), 0);
    chk("full_age15", 32'(age_of(15)), 15);
    // Grant 7 with in_valid high: no allocation while full
    set_in(1, 44, 1, 45, 1, 50);
    grant_valid = 1; grant_addr = 4'd7;
    step();
    grant_valid = 0;
    chk("fg_count", 32'(count), 15);
    chk("fg_ready", 32'(in_ready), 1);
    chk("fg_issue", 32'(issue_dst_tag), 7);
    chk("fg_req", 32'(entry_req), 32'hFF7F);
    chk("fg_age15", 32'(age_of(15)), 14);
    chk("fg_age8", 32'(age_of(8)), 7);
    step();
    set_in(0, 0, 0, 0, 0, 0);
    chk("refill_age7", 32'(age_of(7)), 15);
    chk("refill_count", 32'(count), 16);
    chk("refill_req", 32'(entry_req), 32'hFFFF);

    // Free entry 0, refill with src2 not ready, then grant it
    grant_valid = 1; grant_addr = 4'd0;
    step();
    grant_valid = 0;
    chk("g0_valid", 32'(issue_valid), 1);
    chk("g0_dst", 32'(issue_dst_tag), 10);
    set_in(1, 46, 1, 60, 0, 61);
    step();
    set_in(0, 0, 0, 0, 0, 0);
    chk("nr_age0", 32'(age_of(0)), 15);
    chk("nr_req", 32'(entry_req), 32'hFFFE);
    grant_valid = 1; grant_addr = 4'd0;
    step();
    grant_valid = 0;
    chk("bad_issue", 32'(issue_valid), 0);
    chk("bad_count", 32'(count), 16);
    chk("bad_req", 32'(entry_req), 32'hFFFE);

    // Flush dominates grant and dispatch
    flush = 1; grant_valid = 1; grant_addr = 4'd5;
    set_in(1, 1, 1, 2, 1, 3);
    step();
    flush = 0; grant_valid = 0;
    set_in(0, 0, 0, 0, 0, 0);
    chk("fl_count", 32'(count), 0);
    chk("fl_issue", 32'(issue_valid), 0);
    chk("fl_req", 32'(entry_req), 0);
    chk("fl_ready", 32'(in_ready), 1);

    // Six dispatches, issue one (5 valid, issue_valid high), then async reset
    for (int i = 0; i < 6; i++) begin
      set_in(1, 1, 1, 2, 1, 6'(i));
      step();
    end
    set_in(0, 0, 0, 0, 0, 0);
    grant_valid = 1; grant_addr = 4'd2;
    step();
    grant_valid = 0;
    chk("pre_count", 32'(count), 5);
    chk("pre_issue", 32'(issue_valid), 1);
    chk("pre_age5", 32'(age_of(5)), 4);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_req", 32'(entry_req), 0);
    chk("arst_issue", 32'(issue_valid), 0);
    chk("arst_ready", 32'(in_ready), 1);
    chk("arst_age5", 32'(age_of(5)), 0);
    #3 rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/issue_queue_age.md
# issue_queue_age

16-entry out-of-order issue queue that feeds the age-based select arbiter. Allocates dispatched instructions into free slots, tracks source-operand readiness via tag wakeup broadcasts, presents per-entry opcode/request/age vectors to the arbiter (smallest age = oldest), and consumes the arbiter's 4-bit grant address to issue and free the selected entry. Ages are kept compact (0..count-1), so the arbiter always sees a strict oldest-first ordering.

## Interface
- OPCODE_WIDTH, 7, opcode width (matches arbiter)
- AGE, 5, per-entry age width (matches arbiter)
- TAG_WIDTH, 6, physical register tag width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous squash of all entries
- in_valid  in  1  dispatch request
- in_ready  out  1  slot free; equals (count != 16)
- in_op  in  OPCODE_WIDTH  opcode of dispatched instruction
- in_src1_tag, in_src2_tag  in  TAG_WIDTH  source tags
- in_src1_rdy, in_src2_rdy  in  1  source already available at dispatch
- in_dst_tag  in  TAG_WIDTH  destination tag
- wakeup_valid  in  1  result broadcast valid
- wakeup_tag  in  TAG_WIDTH  broadcast tag
- entry_op  out  16*OPCODE_WIDTH  opcode of entry i at bits [i*OPCODE_WIDTH +: OPCODE_WIDTH]
- entry_req  out  16  entry i valid and both sources ready
- entry_age  out  16*AGE  age of entry i at [i*AGE +: AGE]
- grant_valid  in  1  arbiter selected an entry
- grant_addr  in  4  selected entry index
- issue_valid  out  1  registered issue pulse
- issue_op, issue_src1_tag, issue_src2_tag, issue_dst_tag  out  as input widths  issued entry fields
- count  out  5  number of valid entries

## Operation
- Per entry state: valid, op, src1/src2 tag+rdy, dst tag, age.
- Allocation: when in_valid && in_ready && !flush, write lowest-index entry with valid=0 (priority on entry 0). A slot freed by an issue in the same cycle is not reused that cycle.
- New entry age = count − (issue_fire ? 1 : 0), i.e. youngest after this cycle's issue.
- Wakeup: when wakeup_valid, every valid entry with srcN_tag == wakeup_tag sets srcN_rdy=1. Incoming dispatch whose src tag equals wakeup_tag in the same cycle is written with rdy=1.
- entry_req[i] = valid[i] & src1_rdy[i] & src2_rdy[i], combinational from registered state (wakeup affects req one cycle later).
- issue_fire = grant_valid && entry_req[grant_addr] && !flush. Grant on a non-requesting entry is ignored: no issue, no state change.
- On issue_fire with entry g of age a: valid[g] cleared; every other valid entry with age > a decrements by 1; issue_* fields loaded from entry g.
- count next = count + alloc − issue_fire.
- flush: all valid cleared, count=0, issue_valid=0 next cycle; dominates allocate, wakeup and grant in that cycle.
- Invariant: valid ages form exactly the set {0..count−1}, unique.

## Timing
- Reset (async, immediate): all valid=0, all rdy=0, entry_op/entry_age/tags=0, entry_req=0, count=0, in_ready=1, issue_valid=0, issue_* = 0.
- Dispatch at edge N -> entry visible in entry_req/entry_age after edge N (cycle N+1); earliest issue_valid at cycle N+2 if sources ready and granted in N+1.
- Wakeup at edge N -> entry_req rises in cycle N+1.
- Grant sampled in cycle N -> issue_valid=1 with fields during cycle N+1, single-cycle pulse; entry_req[g]=0 from cycle N+1.
- Full (count=16): in_ready=0; simultaneous issue does not raise in_ready until next cycle.
- Empty: entry_req=0, grants ignored.
- Simultaneous alloc+issue+wakeup in one cycle all take effect; count unchanged on alloc+issue.

## Test plan
- Reset mid-operation with 5 entries valid -> count=0, entry_req=0, issue_valid=0 immediately; in_ready=1.
- Dispatch 3 ready instrs (op=0x33) into empty queue -> entries 0,1,2 ages 0,1,2, entry_req=0x0007, count=3.
- With ages 0,1,2 in entries 0..2, grant_addr=1 -> issue_valid next cycle with entry 1 fields; ages become 0,–,1; count=2.
- Dispatch src1_tag=12 not ready, then wakeup_tag=12 -> entry_req bit rises one cycle after wakeup; same-cycle dispatch+wakeup tag 12 -> req set on first visible cycle.
- Fill 16 entries -> in_ready=0, count=16; grant entry 7 plus in_valid same cycle -> no allocation, count=15, in_ready=1 next cycle, freed entry 7 used by next dispatch with age 15.
- Grant on entry with src2 not ready -> no issue_valid, state unchanged; flush with grant_valid=1 -> count=0, issue_valid stays 0.
